// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin burst arbiter.
//   arb_state_e : IDLE (free arbitration) / LOCKED (burst in progress)
//   DEF_N/DEF_W : default requester count and data width
package mux_rr_arbiter_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder.
//   valid : per-requester request vector
//   ptr   : index scanned first; the scan wraps N-1 -> 0
//   grant : one-hot index of the first valid requester at or after ptr
//   found : any valid bit set
module rr_pick
  import mux_rr_arbiter_pkg::*;
#(
  parameter  int N  = DEF_N,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          found
);

  logic [IW:0] pos;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      // ptr + k folded back into 0..N-1 (works for non power-of-two N)
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!found && valid[pos[IW-1:0]]) begin
        grant[pos[IW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// N-way round-robin arbiter feeding one registered output stage.
// A requester that wins with last=0 holds the grant until its last beat.
//   clk, rst_n       : clock, async active-low reset
//   req_valid/ready  : per-requester handshake (ready is at most one-hot)
//   req_last         : per-requester end-of-burst flag
//   req_data         : packed, requester i at [i*W +: W]
//   out_valid/ready  : output handshake
//   out_data/last/id : registered beat, its last flag and source index
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter  int N  = DEF_N,
  parameter  int W  = DEF_W,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_valid,
  input  logic [N-1:0]  req_last,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]  req_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic [IW-1:0] out_id,
  input  logic          out_ready
);

  arb_state_e state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] holder, holder_nxt;

  logic [N-1:0]        pick_grant;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic [IW-1:0]       sel_idx;
  logic                sel_active;
  logic                can_accept;
  logic                in_fire;
  logic [N-1:0][W-1:0] data_arr;
  logic [W-1:0]        sel_data;
  logic                sel_last;

  assign data_arr = req_data;

  rr_pick #(.N(N)) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .found (pick_found)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < N; k++)
      if (pick_grant[k]) pick_idx = IW'(k);
  end

  // Handshake: in LOCKED the holder keeps ready even with valid low,
  // so a stalled burst simply waits and nobody else gets in.
  always_comb begin
    can_accept = !out_valid || out_ready;
    sel_idx    = (state == LOCKED) ? holder : pick_idx;
    sel_active = (state == LOCKED) || pick_found;
    req_ready  = '0;
    if (rst_n && sel_active) req_ready[sel_idx] = can_accept;
    in_fire  = |(req_ready & req_valid);
    sel_data = data_arr[sel_idx];
    sel_last = req_last[sel_idx];
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    holder_nxt = holder;
    if (in_fire) begin
      if (sel_last) begin
        state_nxt = IDLE;
        ptr_nxt   = (sel_idx == IW'(N-1)) ? '0 : sel_idx + 1'b1;
      end else if (state == IDLE) begin
        state_nxt  = LOCKED;
        holder_nxt = sel_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      holder    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      holder <= holder_nxt;
      // a new beat overwrites the one leaving this cycle; otherwise
      // the stage empties on drain or holds under backpressure
      if (in_fire) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_id    <= sel_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter (N=4, W=8).
module tb_mux_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
    logic          last;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req_valid, req_last, req_ready;
  logic [N*W-1:0]      req_data;
  logic                out_valid, out_last, out_ready;
  logic [W-1:0]        out_data;
  logic [IW-1:0]       out_id;

  logic [N-1:0]        have = '0;
  logic [N-1:0]        gate = '0;
  logic [N-1:0][W-1:0] head_d = '0;
  logic [N-1:0]        head_l = '0;

  beat_t src_all[$];
  beat_t exp_q[$];
  beat_t exp_r[$];
  bit    rand_mode = 1'b0;
  int    tests = 0, fails = 0, out_cnt = 0;

  assign req_valid = have & ~gate;
  assign req_data  = head_d;
  assign req_last  = head_l;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_id(out_id), .out_ready(out_ready)
  );

  task automatic refresh();
    have = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < src_all.size(); k++)
        if (!have[i] && src_all[k].id == IW'(i)) begin
          have[i]   = 1'b1;
          head_d[i] = src_all[k].data;
          head_l[i] = src_all[k].last;
        end
  endtask

  task automatic pop_src(input int i);
    bit done = 1'b0;
    for (int k = 0; k < src_all.size(); k++)
      if (!done && src_all[k].id == IW'(i)) begin
        src_all.delete(k);
        done = 1'b1;
      end
  endtask

  task automatic load(input int id, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.id = IW'(id); b.data = d; b.last = l;
    src_all.push_back(b);
    refresh();
  endtask

  task automatic expect_beat(input int id, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.id = IW'(id); b.data = d; b.last = l;
    if (rand_mode) exp_r.push_back(b); else exp_q.push_back(b);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic drain(input string name, input int max);
    int c = 0;
    while ((src_all.size() != 0 || exp_q.size() != 0 || exp_r.size() != 0 || out_valid) && c < max) begin
      tick();
      c++;
    end
    chk({name, "_drain_in_budget"}, 32'(c < max), 32'd1);
  endtask

  // source: retire the heads that handshook on the coming edge
  initial begin
    logic [N-1:0] fire;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (fire[i]) pop_src(i);
      refresh();
    end
  end

  // monitor: one-hot ready and in-order beats against the scoreboard
  initial begin
    beat_t got, e;
    bit hit;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        tests++;
        if ($countones(req_ready) > 1) begin
          fails++;
          $display("FAIL ready_onehot: got %b required at most one bit", req_ready);
        end
        if (out_valid && out_ready) begin
          out_cnt++;
          got.id = out_id; got.data = out_data; got.last = out_last;
          tests++;
          if (!rand_mode) begin
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL beat_unexpected: got id=%0d data=%0h last=%0b required none", got.id, got.data, got.last);
            end else begin
              e = exp_q.pop_front();
              if (got !== e) begin
                fails++;
                $display("FAIL beat: got id=%0d data=%0h last=%0b required id=%0d data=%0h last=%0b",
                         got.id, got.data, got.last, e.id, e.data, e.last);
              end
            end
          end else begin
            hit = 1'b0;
            for (int k = 0; k < exp_r.size(); k++)
              if (!hit && exp_r[k].id == got.id) begin
                hit = 1'b1;
                e = exp_r[k];
                exp_r.delete(k);
              end
            if (!hit || got !== e) begin
              fails++;
              $display("FAIL rand_order: got id=%0d data=%0h last=%0b required id=%0d data=%0h last=%0b",
                       got.id, got.data, got.last, e.id, e.data, e.last);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    out_ready = 1'b1;

    // reset state, ready suppressed while in reset
    load(1, 8'hEE, 1'b1);
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_out_last",  32'(out_last),  0);
    chk("rst_out_id",    32'(out_id),    0);
    chk("rst_req_ready", 32'(req_ready), 0);
    src_all.delete();
    refresh();
    tick(2);
    rst_n = 1'b1;
    tick();

    // single beats from everyone: one per cycle, ids 0..3, ptr back to 0
    c0 = out_cnt;
    for (int i = 0; i < N; i++) begin
      load(i, 8'h10 + 8'(i), 1'b1);
      expect_beat(i, 8'h10 + 8'(i), 1'b1);
    end
    tick(5);
    chk("single_throughput", 32'(out_cnt - c0), 32'd4);
    drain("single", 50);

    // requester 1 moves ptr to 2, then 2 bursts while 0 waits
    load(1, 8'h20, 1'b1); expect_beat(1, 8'h20, 1'b1);
    drain("ptr_to_2", 50);
    load(2, 8'h30, 1'b0); load(2, 8'h31, 1'b0); load(2, 8'h32, 1'b1);
    load(0, 8'h40, 1'b1);
    expect_beat(2, 8'h30, 1'b0); expect_beat(2, 8'h31, 1'b0);
    expect_beat(2, 8'h32, 1'b1); expect_beat(0, 8'h40, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("burst_ready0_c%0d", k), 32'(req_ready[0]), 32'(k == 4));
    end
    tick();
    drain("burst", 50);

    // backpressure: 5A held for 3 cycles, nothing accepted meanwhile
    out_ready = 1'b0;
    load(1, 8'h5A, 1'b1); load(3, 8'h77, 1'b1);
    expect_beat(1, 8'h5A, 1'b1); expect_beat(3, 8'h77, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_data",  32'(out_data),  32'h5A);
      chk("bp_req_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain("backpressure", 50);

    // wrap: ptr=3 with 0 and 3 valid, then ptr must sit at 1
    load(2, 8'h50, 1'b1); expect_beat(2, 8'h50, 1'b1);
    drain("ptr_to_3", 50);
    load(0, 8'h60, 1'b1); load(3, 8'h63, 1'b1);
    expect_beat(3, 8'h63, 1'b1); expect_beat(0, 8'h60, 1'b1);
    drain("wrap", 50);
    load(0, 8'h70, 1'b1); load(1, 8'h71, 1'b1);
    expect_beat(1, 8'h71, 1'b1); expect_beat(0, 8'h70, 1'b1);
    drain("ptr_is_1", 50);

    // holder stalls mid-burst: ready stays on it, requester 2 waits
    load(1, 8'h80, 1'b0); expect_beat(1, 8'h80, 1'b0);
    tick();
    load(2, 8'h90, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(req_ready), 32'b0010);
    end
    @(posedge clk); #2;
    load(1, 8'h81, 1'b1);
    expect_beat(1, 8'h81, 1'b1); expect_beat(2, 8'h90, 1'b1);
    drain("stall", 50);

    // move ptr to 1, lock requester 1, reset while its beat is held
    load(0, 8'hC0, 1'b1); expect_beat(0, 8'hC0, 1'b1);
    drain("ptr_to_1", 50);
    out_ready = 1'b0;
    load(1, 8'hA0, 1'b0);
    tick();
    chk("lock_out_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("lockrst_out_valid", 32'(out_valid), 0);
    chk("lockrst_out_data",  32'(out_data),  0);
    chk("lockrst_out_id",    32'(out_id),    0);
    chk("lockrst_req_ready", 32'(req_ready), 0);
    src_all.delete();
    refresh();
    tick(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    load(0, 8'hB0, 1'b1); load(1, 8'hB1, 1'b1);
    expect_beat(0, 8'hB0, 1'b1); expect_beat(1, 8'hB1, 1'b1);
    drain("after_reset", 50);

    // random bursts with random backpressure: per-requester order
    rand_mode = 1'b1;
    for (int i = 0; i < N; i++) begin
      int seq = 0;
      for (int b = 0; b < 4; b++) begin
        int len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) begin
          logic [W-1:0] d;
          d = {2'(i), 6'(seq)};
          load(i, d, 1'(j == len - 1));
          expect_beat(i, d, 1'(j == len - 1));
          seq++;
        end
      end
    end
    begin
      int c = 0;
      while ((src_all.size() != 0 || exp_r.size() != 0 || out_valid) && c < 2000) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
        c++;
      end
      out_ready = 1'b1;
      chk("random_drain_in_budget", 32'(c < 2000), 32'd1);
    end
    chk("random_leftover", 32'(exp_r.size()), 0);
    rand_mode = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
